// File: rtl/tdm_mux_pkg.sv
// tdm_mux_pkg
//   Shared definitions for the TDM mux scanner:
//   - operating mode encodings driven on mode_i
//   - sweep sequencer state type
//   - width helpers for the channel select and dwell counter
package tdm_mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    SW_IDLE   = 2'd0,
    SW_RUN    = 2'd1,
    SW_FINISH = 2'd2
  } sweep_state_e;

  // Width of a channel index; never below 1 bit so ports stay legal.
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Width of a counter holding 0..n-1; 1 bit minimum (n == 1 case).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// mux_n_to_1
//   Purely combinational N:1 selector over a packed channel bus.
//   Ports:
//     in_i  [NUM_CH*DATA_W]  packed channels, channel c at in_i[c*DATA_W +: DATA_W]
//     sel_i [SEL_W]          channel index
//     y_o   [DATA_W]         selected channel, zero when sel_i >= NUM_CH
module mux_n_to_1
  import tdm_mux_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 1,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic [NUM_CH*DATA_W-1:0] in_i,
  input  logic [SEL_W-1:0]         sel_i,
  output logic [DATA_W-1:0]        y_o
);

  // A decoded loop rather than an array index so that select codes past
  // NUM_CH (non power-of-two channel counts) fall through to zero.
  always_comb begin
    y_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(sel_i) == c) begin
        y_o = in_i[c*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/tdm_mux_scanner.sv
// tdm_mux_scanner
//   Registered N:1 mux with a channel sequencer (manual select, continuous
//   scan, one-shot sweep, hold). Each output sample carries its channel ID.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     in_i              packed input channels
//     sel_i             manual channel select (MANUAL mode)
//     mode_i            00 MANUAL, 01 SCAN, 10 SWEEP, 11 HOLD
//     start_i           sweep trigger (SWEEP mode, when not busy)
//     out_o, out_ch_o   registered sample and its channel ID
//     out_valid_o       sample valid this cycle
//     busy_o            sweep in progress
//     sweep_done_o      one-cycle pulse at sweep completion
//
//   Sweep sequencer states:
//     state     | meaning
//     SW_IDLE   | no sweep; waiting for start_i
//     SW_RUN    | presenting channels 0..NUM_CH-1, DWELL cycles each
//     SW_FINISH | last channel presented; next edge pulses sweep_done
module tdm_mux_scanner
  import tdm_mux_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 1,
  parameter int DWELL  = 4,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [1:0]               mode_i,
  input  logic                     start_i,
  output logic [DATA_W-1:0]        out_o,
  output logic [SEL_W-1:0]         out_ch_o,
  output logic                     out_valid_o,
  output logic                     busy_o,
  output logic                     sweep_done_o
);

  localparam int DW_W = cnt_width(DWELL);

  logic [1:0]        mode_q, mode_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  sweep_state_e      sw_state_q, sw_state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [SEL_W-1:0]  mux_sel;
  logic [DATA_W-1:0] mux_y;
  logic              mode_change;
  logic              last_ch;
  logic              last_dwell;
  logic              sel_in_range;
  logic              step;

  assign mode_change  = (mode_i != mode_q);
  assign last_ch      = (int'(ptr_q) == NUM_CH - 1);
  assign last_dwell   = (int'(dwell_q) == DWELL - 1);
  assign sel_in_range = (int'(sel_i) < NUM_CH);

  // The mux follows the registered mode so a mode switch never changes the
  // source of a sample taken on the same edge.
  assign mux_sel = (mode_q == MODE_MANUAL) ? sel_i : ptr_q;

  mux_n_to_1 #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_i  (in_i),
    .sel_i (mux_sel),
    .y_o   (mux_y)
  );

  always_comb begin
    mode_d     = mode_i;
    ptr_d      = ptr_q;
    dwell_d    = dwell_q;
    sw_state_d = sw_state_q;
    out_d      = out_q;
    out_ch_d   = out_ch_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    step       = 1'b0;

    if (mode_change) begin
      // Transition edge: restart sequencing, abort any sweep silently,
      // leave the last sample on out/out_ch.
      ptr_d      = '0;
      dwell_d    = '0;
      sw_state_d = SW_IDLE;
    end else begin
      case (mode_q)
        MODE_MANUAL: begin
          out_d    = mux_y;
          out_ch_d = sel_i;
          valid_d  = sel_in_range;
        end
        MODE_SCAN: begin
          out_d    = mux_y;
          out_ch_d = ptr_q;
          valid_d  = 1'b1;
          step     = 1'b1;
        end
        MODE_SWEEP: begin
          case (sw_state_q)
            SW_IDLE: begin
              if (start_i) begin
                sw_state_d = SW_RUN;
                ptr_d      = '0;
                dwell_d    = '0;
              end
            end
            SW_RUN: begin
              out_d    = mux_y;
              out_ch_d = ptr_q;
              valid_d  = 1'b1;
              step     = 1'b1;
              if (last_ch && last_dwell) begin
                sw_state_d = SW_FINISH;
              end
            end
            SW_FINISH: begin
              done_d     = 1'b1;
              sw_state_d = SW_IDLE;
            end
            default: begin
              sw_state_d = SW_IDLE;
            end
          endcase
        end
        default: ; // HOLD: everything frozen, out_valid low
      endcase

      if (step) begin
        if (last_dwell) begin
          dwell_d = '0;
          ptr_d   = last_ch ? '0 : ptr_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_MANUAL;
      ptr_q      <= '0;
      dwell_q    <= '0;
      sw_state_q <= SW_IDLE;
      out_q      <= '0;
      out_ch_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      ptr_q      <= ptr_d;
      dwell_q    <= dwell_d;
      sw_state_q <= sw_state_d;
      out_q      <= out_d;
      out_ch_q   <= out_ch_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign out_o        = out_q;
  assign out_ch_o     = out_ch_q;
  assign out_valid_o  = valid_q;
  assign busy_o       = (sw_state_q != SW_IDLE);
  assign sweep_done_o = done_q;

endmodule

// File: tb/tb_tdm_mux_scanner.sv
module tb_tdm_mux_scanner;
  import tdm_mux_pkg::*;

  localparam int NCH = 16;
  localparam int DW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-channel, DWELL=2 instance
  logic [15:0] in_r;
  logic [3:0]  sel_r;
  logic [1:0]  mode_r;
  logic        start_r;
  logic        out_o;
  logic [3:0]  ch_o;
  logic        valid_o, busy_o, done_o;
  logic [7:0]  got_v;
  assign got_v = {out_o, ch_o, valid_o, busy_o, done_o};

  tdm_mux_scanner #(.NUM_CH(16), .DATA_W(1), .DWELL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_i         (in_r),
    .sel_i        (sel_r),
    .mode_i       (mode_r),
    .start_i      (start_r),
    .out_o        (out_o),
    .out_ch_o     (ch_o),
    .out_valid_o  (valid_o),
    .busy_o       (busy_o),
    .sweep_done_o (done_o)
  );

  // 10-channel, DWELL=1 instance
  logic [9:0] in10;
  logic [3:0] sel10;
  logic [1:0] mode10;
  logic       start10;
  logic       out10;
  logic [3:0] ch10;
  logic       v10, busy10, done10;

  tdm_mux_scanner #(.NUM_CH(10), .DATA_W(1), .DWELL(1)) dut10 (
    .clk          (clk),
    .rst          (rst),
    .in_i         (in10),
    .sel_i        (sel10),
    .mode_i       (mode10),
    .start_i      (start10),
    .out_o        (out10),
    .out_ch_o     (ch10),
    .out_valid_o  (v10),
    .busy_o       (busy10),
    .sweep_done_o (done10)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: counts edges since the mode settled (or since the
  // sweep trigger) and derives the channel by division.
  logic [1:0] m_mode;
  int         m_n, m_sn;
  logic       m_active, m_out, m_valid, m_done;
  logic [3:0] m_ch;

  task automatic model_reset();
    m_mode = MODE_MANUAL; m_n = 0; m_sn = 0; m_active = 1'b0;
    m_out = 1'b0; m_ch = 4'd0; m_valid = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] md, input logic [3:0] s,
                            input logic [15:0] d, input logic st);
    int ch;
    m_done = 1'b0;
    if (md != m_mode) begin
      m_mode = md; m_n = 0; m_active = 1'b0; m_valid = 1'b0;
    end else begin
      case (md)
        MODE_MANUAL: begin m_ch = s; m_out = d[s]; m_valid = 1'b1; end
        MODE_SCAN: begin
          ch = (m_n / DW) % NCH;
          m_ch = ch[3:0]; m_out = d[ch]; m_valid = 1'b1; m_n++;
        end
        MODE_SWEEP: begin
          if (!m_active) begin
            m_valid = 1'b0;
            if (st) begin m_active = 1'b1; m_sn = 0; end
          end else begin
            m_sn++;
            if (m_sn <= NCH * DW) begin
              ch = (m_sn - 1) / DW;
              m_ch = ch[3:0]; m_out = d[ch]; m_valid = 1'b1;
            end else begin
              m_valid = 1'b0; m_done = 1'b1; m_active = 1'b0;
            end
          end
        end
        default: m_valid = 1'b0;
      endcase
    end
  endtask

  function automatic logic [7:0] exp_vec();
    return {m_out, m_ch, m_valid, m_active, m_done};
  endfunction

  // Drive inputs, take one rising edge, update the model, settle 1 time unit.
  task automatic tick(input logic [1:0] md, input logic [3:0] s,
                      input logic [15:0] d, input logic st);
    mode_r = md; sel_r = s; in_r = d; start_r = st;
    @(posedge clk);
    model_edge(md, s, d, st);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_r = 16'hAAAA; sel_r = 4'd0; mode_r = MODE_MANUAL; start_r = 1'b0;
    in10 = 10'd0; sel10 = 4'd0; mode10 = MODE_MANUAL; start10 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_v !== 8'h00) begin
      failures++; $display("FAIL reset_16: got %h expected 00", got_v);
    end
    checks++;
    if ({out10, ch10, v10, busy10, done10} !== 8'h00) begin
      failures++; $display("FAIL reset_10: got %h expected 00", {out10, ch10, v10, busy10, done10});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_manual();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] s;
      s = 4'(i);
      tick(MODE_MANUAL, s, 16'hAAAA, 1'b0);
      checks++;
      if ({out_o, ch_o, valid_o} !== {s[0], s, 1'b1}) begin
        failures++; $display("FAIL manual sel=%0d: got %b/%0d/%b expected %b/%0d/1", i, out_o, ch_o, valid_o, s[0], s);
      end
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL manual_model sel=%0d: got %h expected %h", i, got_v, exp_vec());
      end
    end
  endtask

  task automatic test_scan();
    tick(MODE_SCAN, 4'd0, 16'hAAAA, 1'b0);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++; $display("FAIL scan_switch_valid: got %b expected 0", valid_o);
    end
    for (int i = 0; i < 40; i++) begin
      int c;
      c = (i / 2) % 16;
      tick(MODE_SCAN, 4'd0, 16'hAAAA, 1'b0);
      checks++;
      if ({out_o, ch_o, valid_o} !== {c[0], c[3:0], 1'b1}) begin
        failures++; $display("FAIL scan cycle=%0d: got ch %0d out %b v %b expected ch %0d out %b v 1", i, ch_o, out_o, valid_o, c, c[0]);
      end
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL scan_model cycle=%0d: got %h expected %h", i, got_v, exp_vec());
      end
    end
  endtask

  task automatic test_sweep();
    int vcnt = 0;
    int dcnt = 0;
    tick(MODE_SWEEP, 4'd0, 16'hAAAA, 1'b0);
    for (int c = 0; c < 45; c++) begin
      tick(MODE_SWEEP, 4'd0, 16'hAAAA, (c == 5) || (c == 12));
      if (valid_o === 1'b1) vcnt++;
      if (c == 4 || c == 5) begin
        checks++;
        if (busy_o !== (c == 5)) begin
          failures++; $display("FAIL sweep_busy_rise c=%0d: got %b expected %b", c, busy_o, (c == 5));
        end
      end
      if (done_o === 1'b1) begin
        dcnt++;
        checks++;
        if ({busy_o, ch_o, out_o, valid_o} !== {1'b0, 4'd15, 1'b1, 1'b0}) begin
          failures++; $display("FAIL sweep_done_state c=%0d: got busy %b ch %0d out %b v %b expected 0/15/1/0", c, busy_o, ch_o, out_o, valid_o);
        end
      end
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL sweep_model c=%0d: got %h expected %h", c, got_v, exp_vec());
      end
    end
    checks++;
    if (vcnt !== 32) begin
      failures++; $display("FAIL sweep_valid_count: got %0d expected 32", vcnt);
    end
    checks++;
    if (dcnt !== 1) begin
      failures++; $display("FAIL sweep_done_count: got %0d expected 1", dcnt);
    end
  endtask

  task automatic test_hold_abort();
    tick(MODE_SWEEP, 4'd0, 16'hAAAA, 1'b1);
    repeat (13) tick(MODE_SWEEP, 4'd0, 16'hAAAA, 1'b0);
    checks++;
    if ({ch_o, valid_o} !== {4'd6, 1'b1}) begin
      failures++; $display("FAIL hold_pre ch: got %0d v %b expected 6 v 1", ch_o, valid_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick(MODE_HOLD, 4'd0, 16'h5555, 1'b0);
      checks++;
      if ({out_o, ch_o, valid_o, busy_o, done_o} !== {1'b0, 4'd6, 3'b000}) begin
        failures++; $display("FAIL hold_frozen i=%0d: got %h expected %h", i, got_v, {1'b0, 4'd6, 3'b000});
      end
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL hold_model i=%0d: got %h expected %h", i, got_v, exp_vec());
      end
    end
    for (int i = 0; i < 7; i++) begin
      tick(MODE_SWEEP, 4'd0, 16'hAAAA, 1'b0);
      checks++;
      if ({valid_o, busy_o, done_o} !== 3'b000) begin
        failures++; $display("FAIL hold_return_idle i=%0d: got %b expected 000", i, {valid_o, busy_o, done_o});
      end
    end
  endtask

  task automatic test_back_to_back();
    int dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick(MODE_SWEEP, 4'd0, 16'hAAAA, 1'b1);
      if (done_o === 1'b1) dcnt++;
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL b2b_model i=%0d: got %h expected %h", i, got_v, exp_vec());
      end
    end
    checks++;
    if (dcnt !== 2) begin
      failures++; $display("FAIL b2b_done_count: got %0d expected 2", dcnt);
    end
  endtask

  task automatic test_async_reset();
    tick(MODE_SCAN, 4'd0, 16'hAAAA, 1'b0);
    repeat (5) tick(MODE_SCAN, 4'd0, 16'hAAAA, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (got_v !== 8'h00) begin
      failures++; $display("FAIL async_reset_immediate: got %h expected 00", got_v);
    end
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(MODE_SCAN, 4'd0, 16'hAAAA, 1'b0);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL async_resume_model i=%0d: got %h expected %h", i, got_v, exp_vec());
      end
    end
    checks++;
    if ({ch_o, valid_o} !== {4'd2, 1'b1}) begin
      failures++; $display("FAIL async_resume_ch: got %0d v %b expected 2 v 1", ch_o, valid_o);
    end
  endtask

  task automatic tick10(input logic [1:0] md, input logic [3:0] s, input logic [9:0] d);
    mode10 = md; sel10 = s; in10 = d;
    tick(MODE_HOLD, 4'd0, 16'h0000, 1'b0);
  endtask

  task automatic test_ch10();
    logic [9:0] d;
    d = 10'($urandom);
    tick10(MODE_MANUAL, 4'd12, d);
    checks++;
    if ({out10, ch10, v10} !== {1'b0, 4'd12, 1'b0}) begin
      failures++; $display("FAIL ch10_oor: got out %b ch %0d v %b expected 0/12/0", out10, ch10, v10);
    end
    tick10(MODE_MANUAL, 4'd3, d);
    checks++;
    if ({out10, ch10, v10} !== {d[3], 4'd3, 1'b1}) begin
      failures++; $display("FAIL ch10_manual: got out %b ch %0d v %b expected %b/3/1", out10, ch10, v10, d[3]);
    end
    tick10(MODE_SCAN, 4'd0, d);
    for (int i = 0; i < 25; i++) begin
      int c;
      c = i % 10;
      tick10(MODE_SCAN, 4'd0, d);
      checks++;
      if ({out10, ch10, v10} !== {d[c], c[3:0], 1'b1}) begin
        failures++; $display("FAIL ch10_scan i=%0d: got out %b ch %0d v %b expected %b/%0d/1", i, out10, ch10, v10, d[c], c);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] md;
    md = mode_r;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
      tick(md, 4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 5) == 0));
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL random_model i=%0d mode=%0d: got %h expected %h", i, md, got_v, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_sweep();
    test_hold_abort();
    test_back_to_back();
    test_async_reset();
    test_ch10();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
